udp_tx_framer: RTL and testbench

- Downstream neighbour of axi_to_udp. Consumes its length-tagged UDP payload byte stream.
- Emits a complete Ethernet II + IPv4 + UDP frame byte stream: 42-byte header, payload, zero padding to the 60-byte minimum.
- FCS/preamble are added by the MAC after this block. The block computes the IPv4 header checksum; the UDP checksum is sent as 0x0000.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/ipv4_checksum_accum.sv | 55 +++++
 rtl/udp_tx_framer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared Ethernet / IPv4 / UDP framing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int eth_udp_length_width = 16;

    localparam int eth_mac_header_len   = 14;
    localparam int ipv4_header_len      = 20;
    localparam int udp_header_len       = 8;
    localparam int eth_frame_header_len = eth_mac_header_len + ipv4_header_len + udp_header_len;
    localparam int eth_min_frame_len    = 60;

    localparam logic [15:0] eth_type_ipv4 = 16'h0800;
    localparam logic [7:0]  ip_proto_udp  = 8'd17;

endpackage
`default_nettype wire

// File: rtl/ipv4_checksum_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ipv4_checksum_accum
//  Description : Sequential 16-bit ones'-complement header checksum
//                accumulator (start / add / fold / done).
//  Revision    : 1.0 - initial release
// ============================================================================
module ipv4_checksum_accum (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        i_start,
    input  logic        i_add,
    input  logic [15:0] i_word,
    input  logic        i_fold,
    output logic [15:0] o_sum,
    output logic        o_done
);

    // 20 bits hold the carries of up to 16 added words without loss.
    logic [19:0] r_acc;
    logic [15:0] r_sum;
    logic        r_done;
    logic [16:0] w_fold1;
    logic [16:0] w_fold2;

    // Two end-around-carry folds always leave a clean 16-bit value.
    assign w_fold1 = {1'b0, r_acc[15:0]} + {13'd0, r_acc[19:16]};
    assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'd0, w_fold1[16]};

    // Accumulate words, then fold and invert on request; done pulses with the result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc  <= 20'd0;
            r_sum  <= 16'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_acc <= 20'd0;
            end else if (i_add) begin
                r_acc <= r_acc + {4'd0, i_word};
            end
            if (i_fold) begin
                r_sum  <= ~w_fold2[15:0];
                r_done <= 1'b1;
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/udp_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : udp_tx_framer
//  Description : Wraps a length-tagged UDP payload stream into an Ethernet II
//                + IPv4 + UDP frame, padded to the 60-byte minimum.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_framer
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472,
    parameter int IP_TTL      = 64,
    parameter bit IP_DF       = 1'b1
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [47:0]                     Src_mac,
    input  logic [47:0]                     Dst_mac,
    input  logic [31:0]                     Src_ip,
    input  logic [31:0]                     Dst_ip,
    input  logic [15:0]                     Src_port,
    input  logic [15:0]                     Dst_port,
    input  logic [eth_udp_length_width-1:0] Udp_length,
    input  logic [7:0]                      Udp_data,
    input  logic                            Udp_valid,
    input  logic                            Udp_last,
    output logic                            Udp_ready,
    output logic [7:0]                      Mac_data,
    output logic                            Mac_valid,
    output logic                            Mac_last,
    input  logic                            Mac_ready,
    output logic                            Frame_sent,
    output logic                            Length_error,
    output logic                            Oversize_drop
);

    typedef enum logic [2:0] {
        S_IDLE, S_CSUM, S_HEADER, S_PAYLOAD, S_FILL, S_DONE, S_DISCARD
    } state_t;

    localparam int          c_hdr_bits    = 8 * eth_frame_header_len;
    localparam logic [15:0] c_hdr_len     = 16'(eth_frame_header_len);
    localparam logic [15:0] c_hdr_last    = 16'(eth_frame_header_len - 1);
    localparam logic [15:0] c_min_len     = 16'(eth_min_frame_len);
    localparam logic [15:0] c_ip_udp_len  = 16'(ipv4_header_len + udp_header_len);
    localparam logic [15:0] c_udp_hdr_len = 16'(udp_header_len);
    localparam logic [15:0] c_max_payload = 16'(MAX_PAYLOAD);
    localparam logic [7:0]  c_ttl         = 8'(IP_TTL);
    localparam logic [15:0] c_flags       = IP_DF ? 16'h4000 : 16'h0000;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_need_discard, w_need_discard_nxt;
    logic        r_saw_last, w_saw_last_nxt;
    logic [15:0] r_len, r_id, r_src_port, r_dst_port;
    logic [47:0] r_src_mac, r_dst_mac;
    logic [31:0] r_src_ip, r_dst_ip;
    logic [7:0]  r_mac_data;
    logic        r_mac_valid, r_mac_last, r_length_error, r_oversize_drop;

    logic        w_load, w_sent, w_disc_last;
    logic        w_out_valid, w_out_last, w_length_error, w_oversize, w_latch_cfg;
    logic [7:0]  w_out_data;
    logic        w_udp_ready, w_acc_start, w_acc_add, w_acc_fold, w_acc_done;
    logic [15:0] w_acc_word, w_csum, w_ip_total_len, w_udp_len;
    logic [15:0] w_hdr_end, w_frame_len, w_pos_nxt;
    logic [5:0]  w_hdr_sel;
    logic [8:0]  w_bit_lo;
    logic [c_hdr_bits-1:0] w_hdr;

    assign w_load         = !r_mac_valid || Mac_ready;
    assign w_sent         = r_mac_valid && r_mac_last && Mac_ready;
    assign w_ip_total_len = r_len + c_ip_udp_len;
    assign w_udp_len      = r_len + c_udp_hdr_len;
    assign w_hdr_end      = r_len + c_hdr_len;
    assign w_frame_len    = (w_hdr_end < c_min_len) ? c_min_len : w_hdr_end;
    assign w_pos_nxt      = r_cnt + 16'd1;
    assign w_disc_last    = Udp_valid && Udp_last && !r_saw_last;

    // Whole header as one vector; byte k sits at bits [8*(41-k) +: 8].
    assign w_hdr = {r_dst_mac, r_src_mac, eth_type_ipv4,
                    8'h45, 8'h00, w_ip_total_len, r_id, c_flags, c_ttl, ip_proto_udp,
                    w_csum, r_src_ip, r_dst_ip,
                    r_src_port, r_dst_port, w_udp_len, 16'h0000};
    assign w_hdr_sel = 6'(c_hdr_last) - r_cnt[5:0];
    assign w_bit_lo  = {w_hdr_sel, 3'b000};

    ipv4_checksum_accum u_csum (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_start (w_acc_start),
        .i_add   (w_acc_add),
        .i_word  (w_acc_word),
        .i_fold  (w_acc_fold),
        .o_sum   (w_csum),
        .o_done  (w_acc_done)
    );

    // Header words fed to the checksum, one per CSUM cycle.
    always_comb begin
        w_acc_word = 16'h0000;
        case (r_cnt[3:0])
            4'd0: w_acc_word = 16'h4500;
            4'd1: w_acc_word = w_ip_total_len;
            4'd2: w_acc_word = r_id;
            4'd3: w_acc_word = c_flags;
            4'd4: w_acc_word = {c_ttl, ip_proto_udp};
            4'd5: w_acc_word = r_src_ip[31:16];
            4'd6: w_acc_word = r_src_ip[15:0];
            4'd7: w_acc_word = r_dst_ip[31:16];
            4'd8: w_acc_word = r_dst_ip[15:0];
            default: w_acc_word = 16'h0000;
        endcase
    end

    // Next-state and output-register load decisions.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_need_discard_nxt = r_need_discard;
        w_saw_last_nxt     = r_saw_last;
        w_out_valid        = 1'b0;
        w_out_last         = 1'b0;
        w_out_data         = 8'h00;
        w_length_error     = 1'b0;
        w_oversize         = 1'b0;
        w_latch_cfg        = 1'b0;
        w_udp_ready        = 1'b0;
        w_acc_start        = 1'b0;
        w_acc_add          = 1'b0;
        w_acc_fold         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The first byte is only inspected here; PAYLOAD or DISCARD consumes it.
                if (Udp_valid) begin
                    w_latch_cfg        = 1'b1;
                    w_acc_start        = 1'b1;
                    w_cnt_nxt          = 16'd0;
                    w_need_discard_nxt = 1'b0;
                    w_saw_last_nxt     = 1'b0;
                    if (Udp_length > c_max_payload) begin
                        w_state_nxt = S_DISCARD;
                        w_oversize  = 1'b1;
                    end else begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                // Nine adds, one fold, then one cycle waiting on the registered result.
                if (r_cnt < 16'd9) begin
                    w_acc_add = 1'b1;
                    w_cnt_nxt = w_pos_nxt;
                end else if (r_cnt == 16'd9) begin
                    w_acc_fold = 1'b1;
                    w_cnt_nxt  = w_pos_nxt;
                end else if (w_acc_done) begin
                    w_state_nxt = S_HEADER;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_HEADER: begin
                if (w_load) begin
                    w_out_valid = 1'b1;
                    w_out_data  = w_hdr[w_bit_lo +: 8];
                    w_cnt_nxt   = w_pos_nxt;
                    if (r_cnt == c_hdr_last) begin
                        if (r_len == 16'd0) begin
                            // Nothing to forward, but the upstream byte still has to be drained.
                            w_state_nxt        = S_FILL;
                            w_need_discard_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                // r_cnt is the frame position; the payload count is r_cnt - 42.
                w_udp_ready = w_load;
                if (w_load && Udp_valid) begin
                    w_out_valid = 1'b1;
                    w_out_data  = Udp_data;
                    w_cnt_nxt   = w_pos_nxt;
                    if (Udp_last) begin
                        w_length_error = (w_pos_nxt != w_hdr_end);
                        if (w_pos_nxt == w_frame_len) begin
                            w_out_last  = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end else if (w_pos_nxt == w_hdr_end) begin
                        w_length_error     = 1'b1;
                        w_need_discard_nxt = 1'b1;
                        if (w_pos_nxt == w_frame_len) begin
                            w_out_last  = 1'b1;
                            w_state_nxt = S_DISCARD;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                // Zeros cover both a short payload and the minimum-length pad.
                if (w_load) begin
                    w_out_valid = 1'b1;
                    w_cnt_nxt   = w_pos_nxt;
                    if (w_pos_nxt == w_frame_len) begin
                        w_out_last  = 1'b1;
                        w_state_nxt = r_need_discard ? S_DISCARD : S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (w_sent) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DISCARD: begin
                // Leave only once the upstream frame is gone and our last byte has been taken,
                // so the ID is already bumped before a new frame starts.
                w_udp_ready = !r_saw_last;
                if (w_disc_last) begin
                    w_saw_last_nxt = 1'b1;
                end
                if ((r_saw_last || w_disc_last) && (!r_mac_valid || w_sent)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and position counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 16'd0;
            r_need_discard <= 1'b0;
            r_saw_last     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_need_discard <= w_need_discard_nxt;
            r_saw_last     <= w_saw_last_nxt;
        end
    end

    // Per-frame configuration snapshot and the IP identification counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_len      <= 16'd0;
            r_src_mac  <= 48'd0;
            r_dst_mac  <= 48'd0;
            r_src_ip   <= 32'd0;
            r_dst_ip   <= 32'd0;
            r_src_port <= 16'd0;
            r_dst_port <= 16'd0;
            r_id       <= 16'd0;
        end else begin
            if (w_latch_cfg) begin
                r_len      <= Udp_length;
                r_src_mac  <= Src_mac;
                r_dst_mac  <= Dst_mac;
                r_src_ip   <= Src_ip;
                r_dst_ip   <= Dst_ip;
                r_src_port <= Src_port;
                r_dst_port <= Dst_port;
            end
            if (w_sent) begin
                r_id <= r_id + 16'd1;
            end
        end
    end

    // Single output register: reloads only when empty or being accepted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mac_data      <= 8'h00;
            r_mac_valid     <= 1'b0;
            r_mac_last      <= 1'b0;
            r_length_error  <= 1'b0;
            r_oversize_drop <= 1'b0;
        end else begin
            r_length_error  <= w_length_error;
            r_oversize_drop <= w_oversize;
            if (w_load) begin
                r_mac_valid <= w_out_valid;
                r_mac_last  <= w_out_last;
                if (w_out_valid) begin
                    r_mac_data <= w_out_data;
                end
            end
        end
    end

    assign Udp_ready     = w_udp_ready;
    assign Mac_data      = r_mac_data;
    assign Mac_valid     = r_mac_valid;
    assign Mac_last      = r_mac_last;
    assign Frame_sent    = w_sent;
    assign Length_error  = r_length_error;
    assign Oversize_drop = r_oversize_drop;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_udp_tx_framer
//  Description : Directed self-checking bench for udp_tx_framer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_framer;

    logic        Clk        = 1'b0;
    logic        Rst_n      = 1'b0;
    logic [47:0] Src_mac    = 48'h02AABBCCDDEE;
    logic [47:0] Dst_mac    = 48'h001122334455;
    logic [31:0] Src_ip     = 32'hC0A8010A;
    logic [31:0] Dst_ip     = 32'hC0A80101;
    logic [15:0] Src_port   = 16'h1234;
    logic [15:0] Dst_port   = 16'h5678;
    logic [15:0] Udp_length = 16'd0;
    logic [7:0]  Udp_data   = 8'h00;
    logic        Udp_valid  = 1'b0;
    logic        Udp_last   = 1'b0;
    logic        Udp_ready;
    logic [7:0]  Mac_data;
    logic        Mac_valid;
    logic        Mac_last;
    logic        Mac_ready;
    logic        Frame_sent;
    logic        Length_error;
    logic        Oversize_drop;

    udp_tx_framer #(.MAX_PAYLOAD(1472), .IP_TTL(64), .IP_DF(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Src_mac(Src_mac), .Dst_mac(Dst_mac), .Src_ip(Src_ip), .Dst_ip(Dst_ip),
        .Src_port(Src_port), .Dst_port(Dst_port),
        .Udp_length(Udp_length), .Udp_data(Udp_data), .Udp_valid(Udp_valid),
        .Udp_last(Udp_last), .Udp_ready(Udp_ready),
        .Mac_data(Mac_data), .Mac_valid(Mac_valid), .Mac_last(Mac_last), .Mac_ready(Mac_ready),
        .Frame_sent(Frame_sent), .Length_error(Length_error), .Oversize_drop(Oversize_drop)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (sole writer of the capture state) ----------------
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         rises[$];
    int         frames_done = 0, last_len = 0, n_sent = 0, n_lerr = 0, n_ovs = 0, n_stall_bad = 0;
    bit         prev_stall = 1'b0, prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall && (!Mac_valid || Mac_data !== prev_data)) n_stall_bad++;
            if (Mac_valid && !prev_valid) rises.push_back(cyc);
            if (Mac_valid && Mac_ready) begin
                got_q.push_back(Mac_data);
                if (Mac_last) begin
                    last_len = got_q.size();
                    frames_done++;
                end
            end
            if (Frame_sent)    n_sent++;
            if (Length_error)  n_lerr++;
            if (Oversize_drop) n_ovs++;
            prev_stall = Mac_valid && !Mac_ready;
            prev_data  = Mac_data;
            prev_valid = Mac_valid;
        end
    end

    // ---------------- downstream ready generator ----------------
    bit rnd_ready = 1'b0;
    initial begin
        Mac_ready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            Mac_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- reference helpers ----------------
    logic [7:0]  exp_q[$];
    logic [15:0] exp_id = 16'd0;
    int          last_base = 0;

    function automatic logic [7:0] pbyte(input int i, input int seed);
        return 8'((i * 13 + seed) & 255);
    endfunction

    function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id);
        logic [31:0] s;
        s = 32'h4500 + {16'd0, tl} + {16'd0, id} + 32'h4000 + 32'h4011
          + {16'd0, Src_ip[31:16]} + {16'd0, Src_ip[15:0]}
          + {16'd0, Dst_ip[31:16]} + {16'd0, Dst_ip[15:0]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic build_exp(input int len, input int nbytes, input int seed, input logic [15:0] id);
        logic [15:0]  tl, ul, cs;
        logic [335:0] h;
        tl = 16'(len + 28);
        ul = 16'(len + 8);
        cs = ip_csum(tl, id);
        h  = {Dst_mac, Src_mac, 16'h0800, 8'h45, 8'h00, tl, id, 16'h4000, 8'd64, 8'd17,
              cs, Src_ip, Dst_ip, Src_port, Dst_port, ul, 16'h0000};
        exp_q = {};
        for (int k = 0; k < 42; k++) exp_q.push_back(h[335 - 8 * k -: 8]);
        for (int j = 0; j < len; j++) exp_q.push_back((j < nbytes) ? pbyte(j, seed) : 8'h00);
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
    endtask

    // ---------------- stimulus tasks (called at posedge+1) ----------------
    task automatic drive_bytes(input string tag, input int len, input int nbytes, input int seed);
        int   i;
        int   budget;
        logic acc;
        i = 0;
        budget = 0;
        while (i < nbytes && budget < 20000) begin
            Udp_valid  = 1'b1;
            Udp_length = 16'(len);
            Udp_data   = pbyte(i, seed);
            Udp_last   = (i == nbytes - 1);
            @(negedge Clk);
            acc = Udp_ready;
            @(posedge Clk); #1;
            if (acc) i++;
            budget++;
        end
        Udp_valid = 1'b0;
        Udp_last  = 1'b0;
        check_val({tag, "_consumed"}, i, nbytes);
    endtask

    task automatic wait_frames(input string tag, input int f0);
        int b;
        b = 0;
        while (frames_done == f0 && b < 10000) begin
            @(posedge Clk); #1;
            b++;
        end
        if (frames_done == f0) check_val({tag, "_frame_timeout"}, 0, 1);
        repeat (3) begin @(posedge Clk); #1; end
    endtask

    task automatic run_frame(input string tag, input int len, input int nbytes, input int seed,
                             input int exp_lerr, output int latency);
        int b0, f0, r0, s0, l0, t0, nb, elen;
        b0 = got_q.size();
        f0 = frames_done;
        r0 = rises.size();
        s0 = n_sent;
        l0 = n_lerr;
        t0 = cyc + 1;
        drive_bytes(tag, len, nbytes, seed);
        wait_frames(tag, f0);
        build_exp(len, nbytes, seed, exp_id);
        elen = exp_q.size();
        check_val({tag, "_len"}, got_q.size() - b0, elen);
        check_val({tag, "_lastpos"}, last_len - b0, elen);
        nb = 0;
        for (int k = 0; k < elen && b0 + k < got_q.size(); k++)
            if (got_q[b0 + k] !== exp_q[k]) nb++;
        check_val({tag, "_bytes_bad"}, nb, 0);
        check_val({tag, "_sent"}, n_sent - s0, 1);
        check_val({tag, "_lerr"}, n_lerr - l0, exp_lerr);
        latency   = (rises.size() > r0) ? rises[r0] - t0 : -1;
        last_base = b0;
        exp_id++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   lat, b0, r0, o0, n, bud, seen;
        logic acc;

        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_mac_valid", Mac_valid, 0);
        check_val("rst_mac_last", Mac_last, 0);
        check_val("rst_mac_data", Mac_data, 0);
        check_val("rst_udp_ready", Udp_ready, 0);
        check_val("rst_pulses", {Frame_sent, Length_error, Oversize_drop}, 0);
        Rst_n = 1'b1;
        repeat (2) begin @(posedge Clk); #1; end

        // Known-answer checksum frame.
        run_frame("csum", 100, 100, 3, 0, lat);
        check_val("csum_latency", lat, 12);
        check_val("csum_ip_total_len", {got_q[last_base + 16], got_q[last_base + 17]}, 32'h0080);
        check_val("csum_ip_checksum", {got_q[last_base + 24], got_q[last_base + 25]}, 32'hB711);
        check_val("csum_udp_len", {got_q[last_base + 38], got_q[last_base + 39]}, 32'h006C);

        // Short frames: padding and the exact-minimum boundary.
        run_frame("short1", 1, 1, 40, 0, lat);
        run_frame("short18", 18, 18, 50, 0, lat);

        // Maximum payload under random backpressure.
        rnd_ready = 1'b1;
        run_frame("bp1472", 1472, 1472, 7, 0, lat);
        check_val("bp_stall_stable", n_stall_bad, 0);
        rnd_ready = 1'b0;

        // Length mismatches.
        run_frame("early_last", 20, 10, 11, 1, lat);
        run_frame("late_last", 10, 15, 13, 1, lat);

        // Oversize drop, then an ID-unchanged frame.
        b0 = got_q.size();
        r0 = rises.size();
        o0 = n_ovs;
        drive_bytes("ovs", 1473, 1473, 5);
        repeat (10) begin @(posedge Clk); #1; end
        check_val("ovs_no_bytes", got_q.size() - b0, 0);
        check_val("ovs_no_valid", rises.size() - r0, 0);
        check_val("ovs_pulse", n_ovs - o0, 1);
        run_frame("after_ovs", 22, 22, 77, 0, lat);
        check_val("after_ovs_id", {got_q[last_base + 18], got_q[last_base + 19]}, 32'd6);

        // Reset in the middle of the payload.
        n = 0;
        bud = 0;
        while (n < 5 && bud < 500) begin
            Udp_valid  = 1'b1;
            Udp_length = 16'd100;
            Udp_data   = pbyte(n, 9);
            Udp_last   = 1'b0;
            @(negedge Clk);
            acc = Udp_ready;
            @(posedge Clk); #1;
            if (acc) n++;
            bud++;
        end
        check_val("rst_mid_pre_valid", Mac_valid, 1);
        Rst_n = 1'b0;
        #1;
        check_val("rst_mid_async_valid", Mac_valid, 0);
        check_val("rst_mid_async_ready", Udp_ready, 0);
        Udp_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (Mac_valid) seen++;
        end
        check_val("rst_no_resume", seen, 0);
        exp_id = 16'd0;
        run_frame("post_rst", 5, 5, 21, 0, lat);
        check_val("post_rst_id", {got_q[last_base + 18], got_q[last_base + 19]}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
